keypad_lock_ctrl: RTL and testbench

PIN-entry sequencer for the door-lock datapath. It consumes the one-cycle key_valid/key_value events from the 12-button keypad front end (0-9 digits, 10 = '*', 11 = '#'). It collects digits, verifies the entered PIN against a stored PIN, and drives the unlock, fail and lockout status signals that the display and actuator logic use.

---
 rtl/keypad_lock_ctrl.sv | 141 ++++++++++++++
 tb/tb_keypad_lock_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl: PIN-entry lock sequencer (ENTRY/CHECK/OPEN/FAIL/LOCKOUT); define KEYPAD_PIN_CHANGE_EN to allow PIN change via '*' in OPEN
module keypad_lock_ctrl #(
  parameter int PIN_LEN = 4,
  parameter logic [4*PIN_LEN-1:0] DEFAULT_PIN = 16'h1234,
  parameter int MAX_FAIL = 3,
  parameter int unsigned OPEN_CYCLES = 150000000,
  parameter int unsigned LOCK_CYCLES = 500000000,
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_valid,
  input  logic [3:0] key_value,
  output logic unlock,
  output logic locked,
  output logic fail_pulse,
  output logic pin_changed,
  output logic [2:0] state,
  output logic [3:0] digit_cnt,
  output logic [4*PIN_LEN-1:0] entry_buf,
  output logic [2:0] fail_cnt
);
  localparam int W = 4 * PIN_LEN;
  localparam logic [31:0] T_OPEN = 32'(OPEN_CYCLES - 1);
  localparam logic [31:0] T_LOCK = 32'(LOCK_CYCLES - 1);
  localparam logic [31:0] T_TO = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] MAXF = 3'(MAX_FAIL);
  localparam logic [3:0] LEN = 4'(PIN_LEN);
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT, SET} st_t;
  st_t st, st_n;
  logic [31:0] tmr, tmr_n;
  logic [W-1:0] buf_n, pin;
  logic [3:0] cnt_n;
  logic [2:0] fcnt_n, fcnt_inc;
  logic key, dig, star, hash, full, expired;
  assign state = st;
  assign key = key_valid && key_value < 4'd12;
  assign dig = key && key_value < 4'd10;
  assign star = key && key_value == 4'd10;
  assign hash = key && key_value == 4'd11;
  assign full = digit_cnt == LEN;
  assign expired = tmr == '0;
  assign fcnt_inc = fail_cnt == MAXF ? fail_cnt : fail_cnt + 3'd1;
`ifdef KEYPAD_PIN_CHANGE_EN
  logic chg_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pin <= DEFAULT_PIN;
      pin_changed <= 1'b0;
    end else begin
      pin <= chg_n ? entry_buf : pin;
      pin_changed <= chg_n;
    end
  end
`else
  assign pin = DEFAULT_PIN;
  assign pin_changed = 1'b0;
`endif
  always_comb begin
    st_n = st;
    buf_n = entry_buf;
    cnt_n = digit_cnt;
    fcnt_n = fail_cnt;
    tmr_n = expired ? tmr : tmr - 32'd1;
`ifdef KEYPAD_PIN_CHANGE_EN
    chg_n = 1'b0;
`endif
    case (st)
      IDLE: if (dig) begin
        st_n = ENTRY;
        buf_n = W'(key_value);
        cnt_n = 4'd1;
      end
      ENTRY, SET: if (expired) begin
        st_n = IDLE;
        buf_n = '0;
        cnt_n = '0;
      end else if (key) begin
        tmr_n = T_TO;
        if (dig && !full) begin
          buf_n = (entry_buf << 4) | W'(key_value);
          cnt_n = digit_cnt + 4'd1;
        end else if (star && digit_cnt != '0) begin
          buf_n = entry_buf >> 4;
          cnt_n = digit_cnt - 4'd1;
        end else if (star) st_n = IDLE;
        else if (hash && full && st == ENTRY) st_n = CHECK;
        else if (hash) begin
          st_n = st == ENTRY ? FAIL : IDLE;
          buf_n = '0;
          cnt_n = '0;
`ifdef KEYPAD_PIN_CHANGE_EN
          chg_n = full;
`endif
        end
      end
      CHECK: begin
        st_n = entry_buf == pin ? OPEN : FAIL;
        fcnt_n = entry_buf == pin ? '0 : fail_cnt;
        buf_n = '0;
        cnt_n = '0;
      end
      OPEN: if (expired || hash) st_n = IDLE;
`ifdef KEYPAD_PIN_CHANGE_EN
      else if (star) st_n = SET;
`endif
      FAIL: begin
        fcnt_n = fcnt_inc;
        st_n = fcnt_inc == MAXF ? LOCKOUT : IDLE;
      end
      LOCKOUT: if (expired) begin
        st_n = IDLE;
        fcnt_n = '0;
      end
      default: st_n = IDLE;
    endcase
    // every state change reloads the shared timer for the state being entered
    if (st_n != st) tmr_n = st_n == OPEN ? T_OPEN : st_n == LOCKOUT ? T_LOCK : (st_n == ENTRY || st_n == SET) ? T_TO : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      tmr <= '0;
      entry_buf <= '0;
      digit_cnt <= '0;
      fail_cnt <= '0;
      unlock <= 1'b0;
      locked <= 1'b0;
      fail_pulse <= 1'b0;
    end else begin
      st <= st_n;
      tmr <= tmr_n;
      entry_buf <= buf_n;
      digit_cnt <= cnt_n;
      fail_cnt <= fcnt_n;
      unlock <= st_n == OPEN;
      locked <= st_n == LOCKOUT;
      fail_pulse <= st_n == FAIL;
    end
  end
endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// tb_keypad_lock_ctrl: directed test-plan scenarios plus random key sequences against a queue-based lock model
module tb_keypad_lock_ctrl;
  localparam int L = 4, MAXF = 3, OC = 10, LC = 20, TC = 50;
`ifdef KEYPAD_PIN_CHANGE_EN
  localparam bit PCE = 1'b1;
`else
  localparam bit PCE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, key_valid = 1'b0;
  logic [3:0] key_value = '0;
  logic unlock, locked, fail_pulse, pin_changed;
  logic [2:0] state, fail_cnt;
  logic [3:0] digit_cnt;
  logic [15:0] entry_buf;
  keypad_lock_ctrl #(.PIN_LEN(L), .DEFAULT_PIN(16'h1234), .MAX_FAIL(MAXF), .OPEN_CYCLES(OC),
    .LOCK_CYCLES(LC), .TIMEOUT_CYCLES(TC)) dut (.clk(clk), .rst(rst), .key_valid(key_valid),
    .key_value(key_value), .unlock(unlock), .locked(locked), .fail_pulse(fail_pulse),
    .pin_changed(pin_changed), .state(state), .digit_cnt(digit_cnt), .entry_buf(entry_buf),
    .fail_cnt(fail_cnt));
  always #5 clk = ~clk;
  int checks = 0, passed = 0;
  int cnt_unlock = 0, cnt_locked = 0, cnt_fp = 0;
  string tag = "reset";
  // model: mode code, typed digits, failures, cycles elapsed in the timed mode, current PIN
  int ms, mfail, el;
  int digs[$];
  logic [15:0] mpin;
  bit mchg;
  function automatic logic [15:0] bufval();
    logic [15:0] v = '0;
    foreach (digs[i]) v = {v[11:0], 4'(digs[i])};
    return v;
  endfunction
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", t, got, exp);
  endtask
  task automatic mreset();
    ms = 0; mfail = 0; el = 0; mpin = 16'h1234; mchg = 0;
    digs.delete();
  endtask
  task automatic go(input int s);
    ms = s; el = 0;
  endtask
  task automatic m_edge(input bit v, input logic [3:0] k);
    bit key, dig, star, hash;
    int n;
    key = v && k < 12; dig = key && k < 10; star = key && k == 10; hash = key && k == 11;
    n = digs.size();
    mchg = 0;
    case (ms)
      0: if (dig) begin digs = {int'(k)}; go(1); end
      1, 6: begin
        el++;
        if (el >= TC) begin digs.delete(); go(0); end
        else if (key) begin
          el = 0;
          if (dig) begin if (n < L) digs.push_back(int'(k)); end
          else if (star) begin if (n > 0) void'(digs.pop_back()); else go(0); end
          else if (n == L && ms == 1) go(2);
          else begin
            if (ms == 6 && n == L) begin mpin = bufval(); mchg = 1; end
            digs.delete();
            go(ms == 1 ? 4 : 0);
          end
        end
      end
      2: begin
        if (bufval() == mpin) begin mfail = 0; go(3); end else go(4);
        digs.delete();
      end
      3: begin
        el++;
        if (el >= OC || hash) go(0);
        else if (star && PCE) go(6);
      end
      4: begin mfail = mfail < MAXF ? mfail + 1 : MAXF; go(mfail == MAXF ? 5 : 0); end
      5: begin el++; if (el >= LC) begin mfail = 0; go(0); end end
      default: go(0);
    endcase
  endtask
  task automatic check_model();
    chk({tag, "_state"}, 32'(state), 32'(ms));
    chk({tag, "_unlock"}, 32'(unlock), 32'(ms == 3));
    chk({tag, "_locked"}, 32'(locked), 32'(ms == 5));
    chk({tag, "_fail_pulse"}, 32'(fail_pulse), 32'(ms == 4));
    chk({tag, "_pin_changed"}, 32'(pin_changed), 32'(mchg));
    chk({tag, "_digit_cnt"}, 32'(digit_cnt), 32'(digs.size()));
    chk({tag, "_entry_buf"}, 32'(entry_buf), 32'(bufval()));
    chk({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(mfail));
  endtask
  task automatic step(input bit v, input logic [3:0] k);
    @(negedge clk);
    key_valid = v; key_value = k;
    @(posedge clk);
    m_edge(v, k);
    #1 key_valid = 1'b0;
    check_model();
    cnt_unlock += int'(unlock); cnt_locked += int'(locked); cnt_fp += int'(fail_pulse);
  endtask
  task automatic key(input logic [3:0] k);
    step(1'b1, k);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'($urandom));
  endtask
  task automatic keys(input logic [31:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) key(s[4*i +: 4]);
  endtask
  task automatic zero_counts();
    cnt_unlock = 0; cnt_locked = 0; cnt_fp = 0;
  endtask
  task automatic async_rst();
    @(negedge clk);
    #2 rst = 1'b0;
    mreset();
    #1 check_model();
    chk({tag, "_async_state"}, 32'(state), 0);
    chk({tag, "_async_unlock"}, 32'(unlock), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic rkey(input logic [3:0] k);
    key(k);
    idle($urandom_range(0, 2));
  endtask
  initial begin
    mreset();
    #12 check_model();
    chk("reset_state", 32'(state), 0);
    @(negedge clk) rst = 1'b1;
    tag = "t1"; zero_counts();
    keys(32'h1234B, 5);
    chk("t1_check_state", 32'(state), 2);
    chk("t1_check_unlock", 32'(unlock), 0);
    idle(1);
    chk("t1_unlock_latency", 32'(unlock), 1);
    idle(12);
    chk("t1_open_len", 32'(cnt_unlock), 10);
    chk("t1_end_state", 32'(state), 0);
    tag = "t2"; zero_counts();
    for (int a = 1; a <= 3; a++) begin
      keys(32'h1235B, 5);
      idle(1);
      chk("t2_fail_pulse", 32'(fail_pulse), 1);
      idle(1);
      chk("t2_fail_cnt", 32'(fail_cnt), 32'(a));
    end
    key(4'd1);
    chk("t2_lock_digit_cnt", 32'(digit_cnt), 0);
    idle(25);
    chk("t2_lock_len", 32'(cnt_locked), 20);
    chk("t2_fp_count", 32'(cnt_fp), 3);
    chk("t2_end_fail_cnt", 32'(fail_cnt), 0);
    chk("t2_end_state", 32'(state), 0);
    tag = "t3";
    keys(32'h129A, 4);
    chk("t3_bksp_buf", 32'(entry_buf), 32'h0012);
    chk("t3_bksp_cnt", 32'(digit_cnt), 2);
    keys(32'h34B, 3);
    idle(2);
    chk("t3_unlock", 32'(unlock), 1);
    idle(12);
    tag = "t4"; zero_counts();
    keys(32'h12, 2);
    idle(50);
    chk("t4_to_state", 32'(state), 0);
    chk("t4_to_cnt", 32'(digit_cnt), 0);
    chk("t4_to_buf", 32'(entry_buf), 0);
    chk("t4_to_no_fail", 32'(cnt_fp), 0);
    keys(32'h12B, 3);
    chk("t4_short_fail", 32'(state), 4);
    idle(1);
    chk("t4_short_fcnt", 32'(fail_cnt), 1);
    idle(2);
    tag = "t5";
    keys(32'h123, 3);
    chk("t5_pre_cnt", 32'(digit_cnt), 3);
    async_rst();
    keys(32'h1234B, 5);
    idle(2);
    chk("t5_open", 32'(unlock), 1);
    async_rst();
    keys(32'h1234B, 5);
    idle(2);
    chk("t5_reopen", 32'(unlock), 1);
    idle(12);
`ifdef KEYPAD_PIN_CHANGE_EN
    tag = "t6";
    keys(32'h1234B, 5);
    idle(2);
    keys(32'hA9876B, 6);
    chk("t6_pin_changed", 32'(pin_changed), 1);
    idle(1);
    keys(32'h1234B, 5);
    idle(1);
    chk("t6_old_pin_fail", 32'(fail_pulse), 1);
    idle(2);
    keys(32'h9876B, 5);
    idle(2);
    chk("t6_new_pin_open", 32'(unlock), 1);
    idle(12);
`endif
    tag = "rand";
    for (int a = 0; a < 200; a++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          for (int i = 3; i >= 0; i--) rkey(mpin[4*i +: 4]);
          rkey(4'd11);
        end
        3, 4: begin
          for (int i = 0; i < 4; i++) rkey(4'($urandom_range(0, 9)));
          rkey(4'd11);
        end
        5: begin
          for (int i = $urandom_range(0, 3); i > 0; i--) rkey(4'($urandom_range(0, 9)));
          rkey(4'd11);
        end
        6: for (int i = $urandom_range(1, 6); i > 0; i--) rkey(4'($urandom));
        7: for (int i = $urandom_range(2, 8); i > 0; i--) rkey($urandom_range(0, 3) == 0 ? 4'd10 : 4'($urandom_range(0, 9)));
        8: idle($urandom_range(40, 60));
        default: begin
          rkey(4'd10);
          for (int i = 3; i >= 0; i--) rkey(mpin[4*i +: 4]);
          rkey(4'd11);
        end
      endcase
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
